// File: rtl/tnn_seq_neuron.sv
`timescale 1ns/1ps
// tnn_seq_neuron
// Sequential ternary-weight neuron. A captured feature vector is accumulated
// LANES features per cycle against runtime-loaded ternary weights. The signed
// score is then compared with a runtime-loaded threshold.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   feature-vector handshake; in_ready is high only in IDLE
//   in_data               feature i at bits [i*FEAT_W +: FEAT_W], unsigned
//   cfg_we / cfg_addr     config write; addr 0..N_FEAT-1 selects a weight,
//   cfg_wdata             addr N_FEAT selects the threshold, higher addrs are ignored
//                         weight code in cfg_wdata[1:0]: 01=+1, 11=-1, else 0
//   out_valid / out_ready result handshake
//   out_class             1 when signed score >= signed threshold
//   out_score             signed sum of weight_i * feature_i
module tnn_seq_neuron #(
  parameter  int N_FEAT = 6,
  parameter  int FEAT_W = 2,
  parameter  int LANES  = 1,
  localparam int ACC_W  = $clog2(N_FEAT * (2**FEAT_W - 1) + 1) + 1,
  localparam int ADDR_W = $clog2(N_FEAT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_data,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [ACC_W-1:0]         cfg_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_class,
  output logic [ACC_W-1:0]         out_score
);

  localparam int STEPS = N_FEAT / LANES;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [N_FEAT*FEAT_W-1:0]  feat_r;
  logic [1:0]                weight_r [N_FEAT];
  logic [ACC_W-1:0]          thresh_r;
  logic [ACC_W-1:0]          acc_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic                      out_class_r;
  logic [ACC_W-1:0]          out_score_r;
  logic [ACC_W-1:0]          lane_sum_s;
  logic [ACC_W-1:0]          acc_nxt_s;
  logic                      last_step_s;
  logic                      cls_s;

  // Ternary product of one weight code and one zero-extended feature.
  function automatic logic [ACC_W-1:0] term_f(input logic [1:0] code,
                                              input logic [FEAT_W-1:0] feat);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(feat);
    case (code)
      W_POS:   term_f = ext;
      W_NEG:   term_f = {ACC_W{1'b0}} - ext;
      default: term_f = {ACC_W{1'b0}};
    endcase
  endfunction

  // Sum of the LANES terms of the current lane group, selected by idx_r.
  always_comb begin
    lane_sum_s = {ACC_W{1'b0}};
    for (int s = 0; s < STEPS; s++) begin
      if (idx_r == IDX_W'(s)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_sum_s = lane_sum_s
                     + term_f(weight_r[s*LANES + l],
                              feat_r[(s*LANES + l)*FEAT_W +: FEAT_W]);
        end
      end else begin
        lane_sum_s = lane_sum_s;
      end
    end
  end

  // Running sum, final-step detect and signed threshold compare.
  always_comb begin
    acc_nxt_s   = acc_r + lane_sum_s;
    last_step_s = (idx_r == IDX_W'(STEPS - 1));
    cls_s       = ($signed(acc_nxt_s) >= $signed(thresh_r));
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_ACCUM;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_step_s) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_ACCUM;
      end
      ST_DONE: begin
        // out_valid is always high in DONE, so out_ready alone completes it.
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Capture, accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_r      <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
      out_valid_r <= 1'b0;
      out_class_r <= 1'b0;
      out_score_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            feat_r <= in_data;
            acc_r  <= '0;
            idx_r  <= '0;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_nxt_s;
          idx_r <= idx_r + IDX_W'(1);
          if (last_step_s) begin
            out_score_r <= acc_nxt_s;
            out_class_r <= cls_s;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  // Weight/threshold storage; writes land only while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) weight_r[i] <= 2'b00;
      thresh_r <= '0;
    end else if (cfg_we && (state_r == ST_IDLE)) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (cfg_addr == ADDR_W'(i)) weight_r[i] <= cfg_wdata[1:0];
      end
      if (cfg_addr == ADDR_W'(N_FEAT)) thresh_r <= cfg_wdata;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_class = out_class_r;
  assign out_score = out_score_r;

endmodule

// File: tb/tb_tnn_seq_neuron.sv
`timescale 1ns/1ps
// Directed bench for tnn_seq_neuron: default instance (A), LANES=3 instance (B)
// and N_FEAT=8/FEAT_W=3 instance (C).
module tb_tnn_seq_neuron;

  logic clk;
  logic rst_n;

  // Instance A (defaults) and B (LANES=3) share data and config address/data.
  logic        in_valid, in_ready, cfg_we, out_valid, out_ready, out_class;
  logic [11:0] in_data;
  logic [2:0]  cfg_addr;
  logic [5:0]  cfg_wdata;
  logic [5:0]  out_score;

  logic        in_valid_b, in_ready_b, cfg_we_b, out_valid_b, out_ready_b, out_class_b;
  logic [5:0]  out_score_b;

  logic        in_valid_c, in_ready_c, cfg_we_c, out_valid_c, out_ready_c, out_class_c;
  logic [23:0] in_data_c;
  logic [3:0]  cfg_addr_c;
  logic [6:0]  cfg_wdata_c;
  logic [6:0]  out_score_c;

  int          checks;
  int          errors;
  int          lat;
  logic [5:0]  sc;
  logic [6:0]  sc_c;
  logic        cl;
  logic        bad;

  tnn_seq_neuron u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_score(out_score)
  );

  tnn_seq_neuron #(.N_FEAT(6), .FEAT_W(2), .LANES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_class(out_class_b),
    .out_score(out_score_b)
  );

  tnn_seq_neuron #(.N_FEAT(8), .FEAT_W(3), .LANES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .cfg_we(cfg_we_c), .cfg_addr(cfg_addr_c), .cfg_wdata(cfg_wdata_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_class(out_class_c),
    .out_score(out_score_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [2:0] a, input logic [5:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_b(input logic [2:0] a, input logic [5:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we_b = 1'b1;
    tick();
    cfg_we_b = 1'b0;
  endtask

  task automatic cfg_c(input logic [3:0] a, input logic [6:0] d);
    cfg_addr_c = a; cfg_wdata_c = d; cfg_we_c = 1'b1;
    tick();
    cfg_we_c = 1'b0;
  endtask

  // Offer one vector, then count cycles from the accept edge until out_valid.
  task automatic run_a(input logic [11:0] d, output int l, output logic [5:0] s, output logic c);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    l = 0;
    while (out_valid !== 1'b1 && l < 40) begin tick(); l++; end
    s = out_score; c = out_class;
  endtask

  task automatic run_b(input logic [11:0] d, output int l, output logic [5:0] s, output logic c);
    in_data = d; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    l = 0;
    while (out_valid_b !== 1'b1 && l < 40) begin tick(); l++; end
    s = out_score_b; c = out_class_b;
  endtask

  task automatic run_c(input logic [23:0] d, output int l, output logic [6:0] s, output logic c);
    in_data_c = d; in_valid_c = 1'b1;
    tick();
    in_valid_c = 1'b0;
    l = 0;
    while (out_valid_c !== 1'b1 && l < 40) begin tick(); l++; end
    s = out_score_c; c = out_class_c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_score !== 6'd0) begin errors++; $display("FAIL rst_out_score got %0d exp 0", out_score); end
    checks++; if (out_class !== 1'b0) begin errors++; $display("FAIL rst_out_class got %b exp 0", out_class); end
    rst_n = 1'b1;
    tick();
    run_a(12'hFFF, lat, sc, cl);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rst_latency got %0d exp 6", lat); end
    checks++; if (sc !== 6'd0) begin errors++; $display("FAIL rst_score got %0d exp 0", sc); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL rst_class got %b exp 1", cl); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_hs got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_after_hs got %b exp 0", out_valid); end
  endtask

  task automatic test_signed_score();
    for (int i = 0; i < 3; i++) cfg_a(3'(i), 6'h01);
    for (int i = 3; i < 6; i++) cfg_a(3'(i), 6'h03);
    cfg_a(3'd6, 6'd2);
    run_a(12'h03F, lat, sc, cl);
    checks++; if (sc !== 6'd9) begin errors++; $display("FAIL pos_score got %0d exp 9", sc); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL pos_class got %b exp 1", cl); end
    tick();
    run_a(12'hFC0, lat, sc, cl);
    checks++; if (sc !== 6'b110111) begin errors++; $display("FAIL neg_score got %b exp 110111", sc); end
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL neg_class got %b exp 0", cl); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    run_a(12'h03F, lat, sc, cl);
    checks++; if (sc !== 6'd9) begin errors++; $display("FAIL bp_score got %0d exp 9", sc); end
    in_data = 12'hFC0; in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_score !== 6'd9 || out_class !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold got unstable=%b exp 0", bad); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_hs_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ready=%b exp 0", in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 6) begin errors++; $display("FAIL bp_next_latency got %0d exp 6", lat); end
    checks++; if (out_score !== 6'b110111) begin errors++; $display("FAIL bp_next_score got %b exp 110111", out_score); end
    tick();
  endtask

  task automatic test_config_gating();
    in_data = 12'h03F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cfg_a(3'd0, 6'h03);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (out_score !== 6'd9) begin errors++; $display("FAIL gate_accum_score got %0d exp 9", out_score); end
    checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL gate_accum_class got %b exp 1", out_class); end
    tick();
    cfg_a(3'd7, 6'd20);
    run_a(12'h03F, lat, sc, cl);
    checks++; if (sc !== 6'd9) begin errors++; $display("FAIL gate_addr7_score got %0d exp 9", sc); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL gate_addr7_class got %b exp 1", cl); end
    tick();
    cfg_a(3'd0, 6'h03);
    cfg_a(3'd6, 6'd4);
    run_a(12'h03F, lat, sc, cl);
    checks++; if (sc !== 6'd3) begin errors++; $display("FAIL gate_idle_score got %0d exp 3", sc); end
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL gate_idle_class got %b exp 0", cl); end
    tick();
    // Threshold write in the same cycle as the accept must apply to this vector.
    in_data = 12'h03F; in_valid = 1'b1;
    cfg_addr = 3'd6; cfg_wdata = 6'd3; cfg_we = 1'b1;
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 6) begin errors++; $display("FAIL same_cycle_latency got %0d exp 6", lat); end
    checks++; if (out_score !== 6'd3) begin errors++; $display("FAIL same_cycle_score got %0d exp 3", out_score); end
    checks++; if (out_class !== 1'b1) begin errors++; $display("FAIL same_cycle_class got %b exp 1", out_class); end
    tick();
  endtask

  task automatic test_reset_mid();
    in_data = 12'h03F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_rst_no_output got %b exp 0", bad); end
    run_a(12'hFFF, lat, sc, cl);
    checks++; if (sc !== 6'd0) begin errors++; $display("FAIL mid_rst_score got %0d exp 0", sc); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL mid_rst_class got %b exp 1", cl); end
    tick();
  endtask

  task automatic test_param_sweep();
    for (int i = 0; i < 3; i++) cfg_b(3'(i), 6'h01);
    for (int i = 3; i < 6; i++) cfg_b(3'(i), 6'h03);
    cfg_b(3'd6, 6'd2);
    run_b(12'h03F, lat, sc, cl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lanes3_latency got %0d exp 2", lat); end
    checks++; if (sc !== 6'd9) begin errors++; $display("FAIL lanes3_score got %0d exp 9", sc); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL lanes3_class got %b exp 1", cl); end
    tick();
    run_b(12'hFC0, lat, sc, cl);
    checks++; if (sc !== 6'b110111) begin errors++; $display("FAIL lanes3_neg_score got %b exp 110111", sc); end
    tick();
    for (int i = 0; i < 8; i++) cfg_c(4'(i), 7'h01);
    cfg_c(4'd8, 7'd56);
    run_c(24'hFFFFFF, lat, sc_c, cl);
    checks++; if (lat !== 8) begin errors++; $display("FAIL wide_latency got %0d exp 8", lat); end
    checks++; if (sc_c !== 7'd56) begin errors++; $display("FAIL wide_score got %0d exp 56", sc_c); end
    checks++; if (cl !== 1'b1) begin errors++; $display("FAIL wide_class_eq got %b exp 1", cl); end
    tick();
    cfg_c(4'd8, 7'd57);
    run_c(24'hFFFFFF, lat, sc_c, cl);
    checks++; if (sc_c !== 7'd56) begin errors++; $display("FAIL wide_score2 got %0d exp 56", sc_c); end
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL wide_class_gt got %b exp 0", cl); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 12'h000; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 6'd0;
    out_ready = 1'b1;
    in_valid_b = 1'b0; cfg_we_b = 1'b0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; in_data_c = 24'h000000; cfg_we_c = 1'b0; cfg_addr_c = 4'd0;
    cfg_wdata_c = 7'd0; out_ready_c = 1'b1;
    test_reset();
    test_signed_score();
    test_backpressure();
    test_config_gating();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnn_seq_neuron.md
# tnn_seq_neuron

Sequential, parametrised ternary-weight neuron for the TNN classifier datapath. It generalises the fixed 6-input, 2-bit combinational classifiers to N_FEAT features of FEAT_W bits, processed LANES per cycle. Weights and threshold are runtime-loadable, and valid/ready handshakes sit on both input and output. It sits between the feature quantiser and the class-vote logic; one instance per output neuron.

## Interface
- N_FEAT, 6: number of input features; must be a multiple of LANES
- FEAT_W, 2: unsigned width of each feature
- LANES, 1: features accumulated per cycle
- ACC_W, $clog2(N_FEAT*(2**FEAT_W-1)+1)+1: signed score/threshold width (default 6); derived, not overridden
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  N_FEAT*FEAT_W  feature i at bits [i*FEAT_W +: FEAT_W], unsigned
- cfg_we  in  1  config write strobe
- cfg_addr  in  $clog2(N_FEAT+1)  0..N_FEAT-1 = weight i; N_FEAT = threshold
- cfg_wdata  in  ACC_W  weight in bits [1:0] (01 = +1, 11 = -1, 00/10 = 0); threshold uses the full width, signed
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  1  1 when score >= threshold (signed compare)
- out_score  out  ACC_W  signed sum of weight_i * feature_i

## Operation
- Reset values:
  - FSM: IDLE.
  - Outputs: in_ready=1, out_valid=0, out_class=0, out_score=0.
  - Storage: all weights 0, threshold 0, accumulator 0, lane index 0.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data, clear the accumulator and index, go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle, add the LANES terms for features idx*LANES .. idx*LANES+LANES-1 and increment idx.
  - Term values: weight +1 adds the feature (zero-extended), -1 subtracts it, 0 adds nothing.
  - After N_FEAT/LANES cycles: register out_score and out_class, set out_valid=1, go to DONE.
- DONE:
  - in_ready=0; out_valid, out_score and out_class hold stable.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - out_score and out_class keep their last value until the next result.
- Arithmetic:
  - ACC_W is sized so the worst-case |score| fits; overflow is impossible.
  - The compare is two's-complement signed.
- Config:
  - Writes are honoured only in IDLE; in ACCUM and DONE they are silently dropped.
  - cfg_addr > N_FEAT is ignored.
  - A config write and in_valid in the same IDLE cycle: the write lands at that edge, and the captured vector is evaluated with the new value.
- Reset mid-operation: the transaction is aborted and no out_valid is produced. Weights and threshold return to 0.

## Timing
- Accept edge = T (in_valid && in_ready).
- out_valid rises at T + N_FEAT/LANES (default T+6).
- Next accept is possible 1 cycle after the output handshake edge.
- Minimum period: N_FEAT/LANES + 2 cycles per vector when out_ready is held at 1.
- All outputs are registered; there are no combinational paths from in_* or cfg_* to any output.
- in_ready is a pure state decode (IDLE); it does not depend on out_ready.

## Test plan
- Reset defaults:
  - Stimulus: reset, then send in_data with all features = 3, out_ready=1.
  - Required: out_valid at T+6, out_score=0, out_class=1 (0>=0); in_ready returns to 1 one cycle after the handshake.
- Signed score:
  - Stimulus: weights +1,+1,+1,-1,-1,-1 and threshold 2.
  - Vector features 0-2 = 3, features 3-5 = 0: out_score=9, out_class=1.
  - Vector features 0-2 = 0, features 3-5 = 3: out_score=-9 (6'b110111), out_class=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 throughout.
  - Required: out_valid, out_score and out_class stay stable; in_ready=0.
  - Once out_ready=1, the next vector is accepted at handshake+1.
- Config gating:
  - Stimulus: write weight0=-1 during ACCUM; write cfg_addr=7.
  - Required: the result reflects the old weight0 (both writes dropped); a later IDLE write takes effect.
- Reset mid-ACCUM:
  - Stimulus: assert rst_n=0 at T+3.
  - Required: out_valid stays 0 and in_ready=1 immediately; a later vector with default weights scores 0.
- Parameter sweep:
  - Stimulus: LANES=3 with the weights/vector of the signed-score test.
  - Required: out_valid at T+2, score 9.
  - Also run N_FEAT=8, FEAT_W=3 (ACC_W=7) with all weights +1 and features 7: score 56, class 1 with threshold 56, class 0 with threshold 57.
